rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 datapath mux between four requesters.
- Grants exactly one requester at a time and drives the mux select from the registered grant.
- Passes the granted requester's data word to the shared output.
- Sits in front of any shared 4-source resource in the core, such as write-back source or bus master selection.

Parameters:
DATA_W, 4, width of each requester data word and of out
MAX_HOLD, 8, max BUSY cycles an owner keeps grant while others wait; 0 = no preemption

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request vector, bit i = requester i; held high for the whole transaction
in1  input  DATA_W  requester 0 data
in2  input  DATA_W  requester 1 data
in3  input  DATA_W  requester 2 data
in4  input  DATA_W  requester 3 data
gnt  output  4  one-hot grant, registered; all-zero when idle
gnt_valid  output  1  high while any grant is active
sel  output  2  binary index of owner, registered; drives mux select
out  output  DATA_W  mux output, combinational from sel and inN

Behaviour:
- Reset (async, rst_n low):
  - gnt=0, gnt_valid=0, sel=0.
  - ptr=0, hold_cnt=0, state=IDLE.
  - Takes effect immediately, including mid-transaction. The first grant after rst_n deasserts follows normal IDLE rules.
- States: IDLE, BUSY.
- Winner search: first set bit of candidate vector, scanning circularly ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req != 0: winner registered on next edge (latency 1 cycle, req sampled at edge k, gnt visible after edge k).
  - On that edge: sel=winner index, gnt_valid=1, ptr=winner+1 mod 4, hold_cnt=0, state=BUSY.
  - If req == 0: stay IDLE.
- BUSY, owner release:
  - Release = req[owner] sampled low.
  - If other bits set: handover on the same edge, with no idle bubble. Search starts at owner+1. Update ptr, reset hold_cnt.
  - If no other bits set: gnt=0, gnt_valid=0, state=IDLE, sel keeps last value.
- BUSY, preemption:
  - Condition: MAX_HOLD>0, hold_cnt==MAX_HOLD-1, and any other req bit set.
  - Grant moves on that edge to the next winner, excluding owner. Ptr advances as on release.
  - The preempted owner, if still requesting, competes normally in later rounds.
- BUSY, otherwise: grant held; hold_cnt increments, saturating at MAX_HOLD-1.
- hold_cnt is wide enough for MAX_HOLD-1 (min 1 bit).
- Simultaneous release and preempt condition: treated as release (same result, single rule).
- Owner drops req then re-asserts next cycle: no priority retained, because ptr is already past it.
- Requests arriving while BUSY wait; requesters see no ordering other than round-robin.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - sel matches gnt index whenever gnt_valid=1.
  - gnt/sel change only on clk rising edge or async reset.
- out = in(sel+1) at all times; it keeps showing the last owner's data while idle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1
  - requester count constant NUM_REQ=4
  - select width SEL_W=2
- One sub-module: the existing 4:1 mux, instantiated for out, with width matching DATA_W.
- Round-robin search is a function inside the arbiter, not a separate module.

Test Plan:
- Reset + single request: rst_n low then high, in1..in4=5,1,4,3, req=0100 at edge 2.
  - Expected after edge 2: gnt=0100, sel=2, out=4, gnt_valid=1.
  - req=0 → next edge gnt=0, gnt_valid=0, sel stays 2.
- Round-robin fairness: req=1111 held, each owner drops req for exactly one cycle after 2 BUSY cycles then re-asserts.
  - Expected grant order 0,1,2,3,0, each handover with zero idle cycles.
  - out sequence 5,1,4,3,5.
- Preemption: MAX_HOLD=8, req[0] held forever, req[3] asserted at cycle 3 of BUSY.
  - Expected: gnt moves to 1000 exactly 8 cycles after grant to 0.
  - Then back to 0001 when req[3] drops.
- No preemption without contention: MAX_HOLD=8, only req[1] held 20 cycles.
  - Expected: gnt=0010 continuously, hold_cnt saturates, no glitch on gnt.
- Async reset mid-transaction: rst_n pulled low between edges while gnt=0010.
  - Expected: gnt=0, sel=0, gnt_valid=0 immediately, before the next edge.
  - After release with req=1111: first grant to requester 0.
- Simultaneous release + timeout: owner 2 drops req at the same edge hold_cnt hits MAX_HOLD-1, req=1011.
  - Expected: grant to 3 (search from owner+1), ptr=0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Plain 4:1 data mux; select 0..3 picks in1..in4.
module rr_mux_arbiter_mux
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = '0;
    unique case (sel)
      2'd0: out = in1;
      2'd1: out = in2;
      2'd2: out = in3;
      2'd3: out = in4;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four requesters driving a shared 4:1 mux from
// the registered grant, with optional hold-time preemption.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [DATA_W-1:0]    in1,
  input  logic [DATA_W-1:0]    in2,
  input  logic [DATA_W-1:0]    in3,
  input  logic [DATA_W-1:0]    in4,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 gnt_valid,
  output logic [SEL_W-1:0]     sel,
  output logic [DATA_W-1:0]    out
);

  localparam int unsigned HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   ptr_q,   ptr_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0] others;
  logic               release_own;
  logic               preempt;
  pick_t              pick;

  // First set bit of cand, scanning circularly from start.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] cand,
                                    input logic [SEL_W-1:0]   start);
    pick_t            r;
    logic [SEL_W-1:0] j;
    r = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = start + SEL_W'(i);
      if (!r.found && cand[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    others      = req & ~gnt_q;
    release_own = !req[sel_q];
    preempt     = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST) && (|others);
    pick        = '0;

    unique case (state_q)
      ST_IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick.found) begin
          state_d    = ST_BUSY;
          sel_d      = pick.idx;
          gnt_d      = NUM_REQ'(1) << pick.idx;
          ptr_d      = pick.idx + SEL_W'(1);
          hold_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        // Release and preemption share one path: the owner is always excluded
        // from the search, so the simultaneous case needs no extra rule.
        if (release_own || preempt) begin
          pick = rr_pick(others, sel_q + SEL_W'(1));
          hold_cnt_d = '0;
          if (pick.found) begin
            sel_d = pick.idx;
            gnt_d = NUM_REQ'(1) << pick.idx;
            ptr_d = pick.idx + SEL_W'(1);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_valid = (state_q == ST_BUSY);
    sel       = sel_q;
  end

  rr_mux_arbiter_mux #(
    .DATA_W(DATA_W)
  ) u_mux (
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .sel (sel_q),
    .out (out)
  );

endmodule
